// File: rtl/uart_frame_parser.sv
// uart_frame_parser: byte-stream frame parser behind the UART receive path.
// Hunts for a HEAD0/HEAD1 header, reads LEN, streams LEN payload bytes and
// checks an 8-bit wrap-around checksum of LEN plus the payload. Each frame
// that gets past the header ends with exactly one frame_done or frame_err
// strobe. An inter-byte timeout aborts frames that stall mid-stream.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   uart_rdata[7:0]      received byte, sampled on the rising edge of valid
//   uart_rdata_valid     byte-valid level (new byte = rising edge)
//   uart_rdata_error     receive error for the current byte
//   payload_data[7:0]    payload byte, held until the next payload byte
//   payload_valid        one-cycle strobe per payload byte
//   payload_last         high with the final payload byte
//   frame_done           one-cycle strobe: checksum good
//   frame_err            one-cycle strobe: frame aborted
//   err_code[1:0]        0 checksum, 1 length, 2 timeout, 3 byte error
//   frame_len[7:0]       LEN of the last frame that reached the checksum
//   busy                 high whenever a frame is being parsed
module uart_frame_parser #(
  parameter logic [7:0]  HEAD0          = 8'h55,
  parameter logic [7:0]  HEAD1          = 8'hAA,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_rdata,
  input  logic       uart_rdata_valid,
  input  logic       uart_rdata_error,
  output logic [7:0] payload_data,
  output logic       payload_valid,
  output logic       payload_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] frame_len,
  output logic       busy
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CSUM = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_BYTE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_LEN,
    S_PAY,
    S_CSUM
  } state_e;

  state_e          state_q, state_d;
  logic            valid_q;
  logic [7:0]      rem_q, rem_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      len_q, len_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      pdata_q, pdata_d;
  logic            pvalid_q, pvalid_d;
  logic            plast_q, plast_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [7:0]      flen_q, flen_d;
  logic            busy_q, busy_d;
  logic            stb_c;

  // One byte per rising edge of the valid level.
  assign stb_c = uart_rdata_valid & ~valid_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    sum_d    = sum_q;
    len_d    = len_q;
    tmo_d    = tmo_q;
    pdata_d  = pdata_q;
    pvalid_d = 1'b0;
    plast_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    flen_d   = flen_q;

    if (state_q == S_IDLE) begin
      tmo_d = '0;
      // Errored bytes never open a frame.
      if (stb_c && !uart_rdata_error && uart_rdata == HEAD0) begin
        state_d = S_HDR1;
      end
    end else if (stb_c) begin
      // A byte arriving on the timeout cycle wins over the timeout.
      tmo_d = '0;
      if (uart_rdata_error) begin
        err_d   = 1'b1;
        code_d  = ERR_BYTE;
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_HDR1: begin
            if (uart_rdata == HEAD1) begin
              state_d = S_LEN;
            end else if (uart_rdata != HEAD0) begin
              state_d = S_IDLE;
            end
          end
          S_LEN: begin
            rem_d = uart_rdata;
            sum_d = uart_rdata;
            len_d = uart_rdata;
            if (uart_rdata > MAX_LEN_B) begin
              err_d   = 1'b1;
              code_d  = ERR_LEN;
              state_d = S_IDLE;
            end else if (uart_rdata == 8'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_PAY;
            end
          end
          S_PAY: begin
            pdata_d  = uart_rdata;
            pvalid_d = 1'b1;
            plast_d  = (rem_q == 8'd1);
            sum_d    = sum_q + uart_rdata;
            rem_d    = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_d = S_CSUM;
            end
          end
          S_CSUM: begin
            flen_d = len_q;
            if (uart_rdata == sum_q) begin
              done_d = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = ERR_CSUM;
            end
            state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (tmo_q == TMO_LAST) begin
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      state_d = S_IDLE;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    // busy follows the state being entered so it drops with the end strobe.
    busy_d = (state_d != S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rem_q    <= '0;
      sum_q    <= '0;
      len_q    <= '0;
      tmo_q    <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      plast_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      flen_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      valid_q  <= uart_rdata_valid;
      rem_q    <= rem_d;
      sum_q    <= sum_d;
      len_q    <= len_d;
      tmo_q    <= tmo_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      plast_q  <= plast_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
      flen_q   <= flen_d;
      busy_q   <= busy_d;
    end
  end

  assign payload_data  = pdata_q;
  assign payload_valid = pvalid_q;
  assign payload_last  = plast_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;
  assign err_code      = code_q;
  assign frame_len     = flen_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser: directed frames plus randomized traffic,
// expected events queued by a byte-level reference model and checked by an
// independent monitor (content, cycle of arrival and busy level).
module tb_uart_frame_parser;

  localparam int T    = 40;
  localparam int MAXL = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] uart_rdata;
  logic       uart_rdata_valid;
  logic       uart_rdata_error;
  logic [7:0] payload_data;
  logic       payload_valid;
  logic       payload_last;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] frame_len;
  logic       busy;

  uart_frame_parser #(
    .HEAD0(8'h55), .HEAD1(8'hAA), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .uart_rdata(uart_rdata), .uart_rdata_valid(uart_rdata_valid),
    .uart_rdata_error(uart_rdata_error),
    .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_last(payload_last), .frame_done(frame_done),
    .frame_err(frame_err), .err_code(err_code), .frame_len(frame_len),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 payload byte, 1 frame_done, 2 frame_err
  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       last;
    logic [1:0] code;
    logic [7:0] len;
    int         at;
  } ev_t;

  ev_t        expq[$];
  logic [7:0] fb[$];     // bytes of the frame currently being received
  int         total = 0;
  int         bad = 0;
  int         last_stb = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] d, input logic l,
                         input logic [1:0] c, input logic [7:0] len, input int at);
    ev_t e;
    e.kind = kind; e.data = d; e.last = l; e.code = c; e.len = len; e.at = at;
    expq.push_back(e);
  endtask

  // Reference model: frame position is simply the number of bytes collected.
  task automatic model_byte(input logic [7:0] b, input logic e, input int at);
    int n;
    int len;
    logic [7:0] s;
    n = fb.size();
    if (n == 0) begin
      if (!e && b == 8'h55) fb.push_back(b);
      return;
    end
    if (e) begin
      push_ev(2, 0, 0, 2'd3, 0, at);
      fb.delete();
      return;
    end
    if (n == 1) begin
      if (b == 8'hAA) fb.push_back(b);
      else if (b != 8'h55) fb.delete();
    end else if (n == 2) begin
      if (int'(b) > MAXL) begin
        push_ev(2, 0, 0, 2'd1, 0, at);
        fb.delete();
      end else begin
        fb.push_back(b);
      end
    end else begin
      len = int'(fb[2]);
      if (n - 3 < len) begin
        push_ev(0, b, (n - 3 == len - 1), 0, 0, at);
        fb.push_back(b);
      end else begin
        s = 8'd0;
        for (int i = 2; i < n; i++) s = s + fb[i];
        if (b == s) push_ev(1, 0, 0, 0, fb[2], at);
        else        push_ev(2, 0, 0, 2'd0, fb[2], at);
        fb.delete();
      end
    end
  endtask

  // Silence of d cycles until the next byte: an open frame times out if d > T.
  task automatic model_gap(input int d);
    if (fb.size() > 0 && d > T) begin
      push_ev(2, 0, 0, 2'd2, 0, last_stb + T);
      fb.delete();
    end
  endtask

  // Called just after a posedge; stb spacing to the next byte is hold+gap.
  task automatic send(input logic [7:0] b, input logic e, input int hold, input int gap);
    uart_rdata       = b;
    uart_rdata_error = e;
    uart_rdata_valid = 1'b1;
    last_stb = cyc + 1;
    model_byte(b, e, last_stb);
    model_gap(hold + gap);
    repeat (hold) @(posedge clk);
    #1;
    uart_rdata_valid = 1'b0;
    uart_rdata_error = 1'b0;
    uart_rdata       = 8'($urandom);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i], 1'b0, 1, 1);
  endtask

  task automatic rnd_send(input logic [7:0] b);
    int hold, r, d;
    logic e;
    e    = ($urandom_range(0, 59) == 0);
    hold = $urandom_range(1, 3);
    r    = $urandom_range(0, 39);
    if (r == 0)      d = T;
    else if (r == 1) d = T + 1;
    else if (r == 2) d = T + 2 + $urandom_range(0, 5);
    else             d = hold + $urandom_range(1, 3);
    send(b, e, hold, d - hold);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rdata_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {payload_data, payload_valid, payload_last, frame_done,
                          frame_err, err_code, frame_len, busy}, 0);
    chk("reset_no_pending", expq.size(), 0);
    rst = 1'b0;
    fb.delete();
  endtask

  // Monitor: pops one expected event per DUT strobe.
  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst) begin
      if (frame_done || frame_err) begin
        chk("done_err_exclusive", {31'd0, frame_done & frame_err}, 0);
        chk("busy_at_end", busy, 0);
      end
      if (payload_valid) begin
        if (expq.size() == 0) chk("unexpected_payload", 1, 0);
        else begin
          e = expq.pop_front();
          chk("payload_kind", 0, e.kind);
          chk("payload_data", payload_data, e.data);
          chk("payload_last", payload_last, e.last);
          chk("payload_cycle", cyc, e.at);
          chk("busy_in_payload", busy, 1);
        end
      end
      if (frame_done) begin
        if (expq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = expq.pop_front();
          chk("done_kind", 1, e.kind);
          chk("done_len", frame_len, e.len);
          chk("done_cycle", cyc, e.at);
        end
      end
      if (frame_err) begin
        if (expq.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          e = expq.pop_front();
          chk("err_kind", 2, e.kind);
          chk("err_code", err_code, e.code);
          if (e.code == 2'd0) chk("err_len", frame_len, e.len);
          chk("err_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] s[$];
    logic [7:0] q[$];
    logic [7:0] ck;
    int len, r, cut;

    rst = 1'b1;
    uart_rdata = 8'h00;
    uart_rdata_valid = 1'b0;
    uart_rdata_error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {payload_data, payload_valid, payload_last, frame_done,
                          frame_err, err_code, frame_len, busy}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Good frame, bad checksum, zero length, over-length.
    s = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; send_seq(s);
    s = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h00};        send_seq(s);
    s = '{8'h55, 8'hAA, 8'h00, 8'h00};                      send_seq(s);
    s = '{8'h55, 8'hAA, 8'h41, 8'h11, 8'h22, 8'h69};        send_seq(s);

    // Resync with the first HEAD0 held high for 10 cycles.
    send(8'h55, 1'b0, 10, 1);
    chk("busy_after_head0", busy, 1);
    s = '{8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F}; send_seq(s);

    // Timeout after silence, and the stb-spacing boundary T vs T+1.
    s = '{8'h55, 8'hAA, 8'h04}; send_seq(s);
    send(8'h01, 1'b0, 1, T + 5);
    s = '{8'h55, 8'hAA}; send_seq(s);
    send(8'h01, 1'b0, 1, T - 1);
    s = '{8'h09, 8'h0A}; send_seq(s);
    s = '{8'h55, 8'hAA}; send_seq(s);
    send(8'h01, 1'b0, 1, T);
    s = '{8'h09, 8'h0A}; send_seq(s);

    // Byte error on the second payload byte, and in IDLE.
    s = '{8'h55, 8'hAA, 8'h03, 8'h10}; send_seq(s);
    send(8'h20, 1'b1, 1, 1);
    send(8'h55, 1'b1, 1, 1);
    s = '{8'h30, 8'hAA}; send_seq(s);

    // Maximum legal length.
    q.delete(); ck = 8'(MAXL);
    q.push_back(8'h55); q.push_back(8'hAA); q.push_back(8'(MAXL));
    for (int i = 0; i < MAXL; i++) begin
      q.push_back(8'($urandom)); ck = ck + q[q.size() - 1];
    end
    q.push_back(ck); send_seq(q);

    // Reset mid-frame, then a good frame.
    s = '{8'h55, 8'hAA, 8'h02, 8'h01}; send_seq(s);
    do_reset();
    @(posedge clk); #1;
    s = '{8'h55, 8'hAA, 8'h01, 8'h05, 8'h06}; send_seq(s);

    // Randomized traffic.
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 4)) rnd_send(8'($urandom));
      end else begin
        r = $urandom_range(0, 9);
        if (r == 0)      len = MAXL;
        else if (r == 1) len = MAXL + 1;
        else if (r == 2) len = $urandom_range(0, 80);
        else             len = $urandom_range(0, 12);
        q.delete(); ck = 8'(len);
        q.push_back(8'h55); q.push_back(8'hAA); q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
          q.push_back(8'($urandom)); ck = ck + q[q.size() - 1];
        end
        if ($urandom_range(0, 7) == 0) ck = ck ^ 8'(1 + $urandom_range(0, 254));
        q.push_back(ck);
        cut = ($urandom_range(0, 19) == 0) ? $urandom_range(1, q.size() - 1) : -1;
        for (int i = 0; i < q.size(); i++) begin
          if (i == cut) begin
            do_reset();
            @(posedge clk); #1;
            break;
          end
          rnd_send(q[i]);
        end
      end
    end

    // Let any open frame time out, then require every expectation consumed.
    model_gap(1 << 30);
    repeat (T + 10) @(posedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
